sti_rx: RTL and testbench

STI_RX -- requirements
Module: sti_rx

---
 rtl/sti_rx.sv | 180 ++++++++++++++++++
 tb/tb_sti_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sti_rx.sv
// -----------------------------------------------------------------------------
// sti_rx -- serial-to-parallel frame receiver
//
// Collects 8/16/24/32-bit frames from a qualified serial bit stream.
// Frame length and bit order are latched with the first bit of each frame.
// The completed word is handed to a one-entry output register with a
// valid/ready handshake. A frame that completes while that register still
// holds an undelivered word is dropped, and the sticky ovf flag is set.
//
// Ports
//   clk         in   1   clock, rising edge
//   reset       in   1   synchronous, active-high reset
//   si_data     in   1   serial data bit, sampled when si_valid=1
//   si_valid    in   1   serial bit qualifier
//   cfg_length  in   2   frame length: 00=8, 01=16, 10=24, 11=32 bits
//   cfg_msb     in   1   1 = first bit is MSB, 0 = first bit is LSB
//   po_data     out  32  received word, right-aligned, upper bits zero
//   po_valid    out  1   po_data holds an undelivered word
//   po_ready    in   1   consumer takes po_data when po_valid & po_ready
//   ovf         out  1   sticky: a completed frame was dropped (or aborted)
//   frame_cnt   out  8   number of words loaded into po_data, wraps at 255
//   busy        out  1   frame in progress (state RECV)
//
// Build option
//   STI_RX_GAP_ABORT_EN  defined: si_valid=0 during a frame discards the
//                        partial frame, returns to IDLE and sets ovf.
//                        undefined (default): a gap simply pauses the frame.
// -----------------------------------------------------------------------------
module sti_rx (
    input  logic        clk,
    input  logic        reset,
    input  logic        si_data,
    input  logic        si_valid,
    input  logic [1:0]  cfg_length,
    input  logic        cfg_msb,
    output logic [31:0] po_data,
    output logic        po_valid,
    input  logic        po_ready,
    output logic        ovf,
    output logic [7:0]  frame_cnt,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  len_q, len_d;
    logic        msb_q, msb_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] po_data_q, po_data_d;
    logic        po_valid_q, po_valid_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;

    logic        frame_done;
    logic        gap_abort;
    logic [4:0]  last_idx;
    logic [31:0] lsb_word;
    logic [31:0] msb_word;
    logic [31:0] word_in;

    // Index of the completing bit: N-1 = 8*(len+1)-1.
    assign last_idx = {len_q, 3'b111};

    // LSB-first: the incoming bit lands at its own bit position.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_lsb
            localparam logic [4:0] IDX = 5'(gi);
            assign lsb_word[gi] = (cnt_q == IDX) ? si_data : acc_q[gi];
        end
    endgenerate

    // MSB-first: shift left, so after N bits frame bit 0 sits at N-1.
    // The accumulator starts from zero, so bits above N-1 stay clear.
    assign msb_word = {acc_q[30:0], si_data};
    assign word_in  = msb_q ? msb_word : lsb_word;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        msb_d       = msb_q;
        acc_d       = acc_q;
        po_data_d   = po_data_q;
        po_valid_d  = po_valid_q;
        ovf_d       = ovf_q;
        frame_cnt_d = frame_cnt_q;
        frame_done  = 1'b0;
        gap_abort   = 1'b0;

        case (state_q)
            IDLE: begin
                if (si_valid) begin
                    state_d = RECV;
                    cnt_d   = 5'd1;
                    len_d   = cfg_length;
                    msb_d   = cfg_msb;
                    acc_d   = {31'b0, si_data};
                end
            end
            RECV: begin
                if (si_valid) begin
                    acc_d = word_in;
                    if (cnt_q == last_idx) begin
                        frame_done = 1'b1;
                        state_d    = IDLE;
                        cnt_d      = 5'd0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end else begin
`ifdef STI_RX_GAP_ABORT_EN
                    gap_abort = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = 5'd0;
`else
                    gap_abort = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
            end
        endcase

        // Output register: a completing frame wins over a plain acceptance
        // so a simultaneous accept+complete keeps po_valid high.
        if (frame_done) begin
            if (!po_valid_q || po_ready) begin
                po_data_d   = word_in;
                po_valid_d  = 1'b1;
                frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (po_valid_q && po_ready) begin
            po_valid_d = 1'b0;
        end

        if (gap_abort) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            len_q       <= 2'd0;
            msb_q       <= 1'b0;
            acc_q       <= 32'd0;
            po_data_q   <= 32'd0;
            po_valid_q  <= 1'b0;
            ovf_q       <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            msb_q       <= msb_d;
            acc_q       <= acc_d;
            po_data_q   <= po_data_d;
            po_valid_q  <= po_valid_d;
            ovf_q       <= ovf_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign po_data   = po_data_q;
    assign po_valid  = po_valid_q;
    assign ovf       = ovf_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = (state_q == RECV);

endmodule

// File: tb/tb_sti_rx.sv
// -----------------------------------------------------------------------------
// tb_sti_rx -- self-checking bench for sti_rx
//
// Stimulus pushes each word it expects to be delivered into a queue; a
// monitor sampling on the falling edge pops and compares whenever a
// po_valid & po_ready handshake is about to happen. Directed checks cover
// reset values, latency, overflow, gap handling and frame_cnt wrap.
// -----------------------------------------------------------------------------
module tb_sti_rx;

    logic        clk;
    logic        reset;
    logic        si_data;
    logic        si_valid;
    logic [1:0]  cfg_length;
    logic        cfg_msb;
    logic [31:0] po_data;
    logic        po_valid;
    logic        po_ready;
    logic        ovf;
    logic [7:0]  frame_cnt;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    sti_rx dut (
        .clk        (clk),
        .reset      (reset),
        .si_data    (si_data),
        .si_valid   (si_valid),
        .cfg_length (cfg_length),
        .cfg_msb    (cfg_msb),
        .po_data    (po_data),
        .po_valid   (po_valid),
        .po_ready   (po_ready),
        .ovf        (ovf),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Scoreboard monitor: a handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (!reset && po_valid === 1'b1 && po_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got 0x%08h, expected no word", po_data);
            end else begin
                check("sb_word", po_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        si_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        si_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Send frame bits first..last of word w. cfg is only driven correctly on
    // bit 0; later bits drive inverted cfg to show it is ignored mid-frame.
    // si_valid is left high so consecutive calls run back-to-back.
    task automatic send_bits(input logic [31:0] w, input logic [1:0] len,
                             input logic msb, input int first, input int last);
        int n;
        n = 8 * (int'(len) + 1);
        for (int k = first; k <= last; k++) begin
            si_valid = 1'b1;
            si_data  = msb ? w[n - 1 - k] : w[k];
            if (k == 0) begin
                cfg_length = len;
                cfg_msb    = msb;
            end else begin
                cfg_length = ~len;
                cfg_msb    = ~msb;
            end
            tick();
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic [1:0] len, input logic msb);
        send_bits(w, len, msb, 0, 8 * (int'(len) + 1) - 1);
    endtask

    initial begin
        reset      = 1'b1;
        si_data    = 1'b0;
        si_valid   = 1'b0;
        cfg_length = 2'b00;
        cfg_msb    = 1'b0;
        po_ready   = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_po_data", po_data, 32'h0);
        check("rst_po_valid", {31'b0, po_valid}, 32'h0);
        check("rst_ovf", {31'b0, ovf}, 32'h0);
        check("rst_frame_cnt", {24'b0, frame_cnt}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);

        // 8-bit MSB-first 0xA5, latency and one-cycle valid pulse
        po_ready = 1'b1;
        exp_q.push_back(32'h0000_00A5);
        send_bits(32'hA5, 2'b00, 1'b1, 0, 0);
        check("busy_after_bit0", {31'b0, busy}, 32'h1);
        send_bits(32'hA5, 2'b00, 1'b1, 1, 7);
        si_valid = 1'b0;
        check("a5_valid_rise", {31'b0, po_valid}, 32'h1);
        check("a5_frame_cnt", {24'b0, frame_cnt}, 32'h1);
        check("a5_busy_done", {31'b0, busy}, 32'h0);
        tick();
        check("a5_valid_pulse_end", {31'b0, po_valid}, 32'h0);

        // 16-bit LSB-first and 32-bit MSB-first
        exp_q.push_back(32'h0000_1234);
        send_word(32'h1234, 2'b01, 1'b0);
        exp_q.push_back(32'hDEAD_BEEF);
        send_word(32'hDEADBEEF, 2'b11, 1'b1);
        idle(2);
        check("cnt_after_3", {24'b0, frame_cnt}, 32'h3);

        // Back-to-back frames with consumer stalled: second one is dropped
        do_reset();
        po_ready = 1'b0;
        exp_q.push_back(32'h0000_000F);
        send_word(32'h0F, 2'b00, 1'b1);
        send_word(32'hF0, 2'b00, 1'b1);
        si_valid = 1'b0;
        check("ovf_hold_data", po_data, 32'h0000_000F);
        check("ovf_set", {31'b0, ovf}, 32'h1);
        check("ovf_frame_cnt", {24'b0, frame_cnt}, 32'h1);
        check("ovf_valid", {31'b0, po_valid}, 32'h1);
        idle(2);
        check("ovf_data_stable", po_data, 32'h0000_000F);
        po_ready = 1'b1;
        tick();
        check("ovf_valid_clear", {31'b0, po_valid}, 32'h0);
        check("ovf_sticky", {31'b0, ovf}, 32'h1);

        // 24-bit frame interrupted after 10 bits by a 3-cycle gap
        do_reset();
        send_bits(32'hABCDEF, 2'b10, 1'b1, 0, 9);
        si_valid = 1'b0;
        tick();
        tick();
        tick();
`ifdef STI_RX_GAP_ABORT_EN
        check("gap_ovf", {31'b0, ovf}, 32'h1);
        check("gap_busy", {31'b0, busy}, 32'h0);
        check("gap_no_valid", {31'b0, po_valid}, 32'h0);
        exp_q.push_back(32'h0000_005A);
        send_word(32'h5A, 2'b00, 1'b0);
        idle(2);
        check("gap_new_frame_cnt", {24'b0, frame_cnt}, 32'h1);
`else
        check("gap_busy_hold", {31'b0, busy}, 32'h1);
        check("gap_no_valid", {31'b0, po_valid}, 32'h0);
        exp_q.push_back(32'h00AB_CDEF);
        send_bits(32'hABCDEF, 2'b10, 1'b1, 10, 23);
        si_valid = 1'b0;
        check("gap_resume_data", po_data, 32'h00AB_CDEF);
        check("gap_ovf_clear", {31'b0, ovf}, 32'h0);
        idle(2);
        check("gap_frame_cnt", {24'b0, frame_cnt}, 32'h1);
`endif

        // Reset in the middle of a 16-bit frame
        do_reset();
        exp_q.push_back(32'h0000_003C);
        send_word(32'h3C, 2'b00, 1'b1);
        idle(2);
        send_bits(32'h5555, 2'b01, 1'b1, 0, 4);
        reset    = 1'b1;
        si_valid = 1'b1;
        si_data  = 1'b1;
        tick();
        reset    = 1'b0;
        si_valid = 1'b0;
        check("midrst_po_data", po_data, 32'h0);
        check("midrst_po_valid", {31'b0, po_valid}, 32'h0);
        check("midrst_ovf", {31'b0, ovf}, 32'h0);
        check("midrst_frame_cnt", {24'b0, frame_cnt}, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'h0);
        tick();
        exp_q.push_back(32'h0000_BEEF);
        send_word(32'hBEEF, 2'b01, 1'b0);
        si_valid = 1'b0;
        check("midrst_beef", po_data, 32'h0000_BEEF);
        idle(2);

        // 257 back-to-back 8-bit frames: frame_cnt wraps to 1
        do_reset();
        for (int i = 0; i < 257; i++) begin
            logic [31:0] w;
            w = 32'(i[7:0]);
            exp_q.push_back(w);
            send_word(w, 2'b00, i[0]);
        end
        idle(3);
        check("wrap_frame_cnt", {24'b0, frame_cnt}, 32'h1);
        check("wrap_ovf", {31'b0, ovf}, 32'h0);

        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
